fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS CPU. It holds the PC and presents it to instruction memory. It captures the fetched word into the IF/ID register and drives the opcode field into the ID-stage control decoder. It also applies stall, flush, branch and jump redirects from the ID stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on flush or while idle (sll $0,$0,0).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  leaves IDLE when sampled high.
- stall_i  in  1  hazard unit: hold PC and IF/ID this cycle.
- branch_taken_i  in  1  ID-stage beq resolved taken.
- branch_target_i  in  32  branch target byte address from ID.
- jump_i  in  1  ID-stage decoder flagged j (opcode 6'b000010).
- inst_addr_o  out  32  byte address to instruction memory; equals PC register.
- inst_data_i  in  32  instruction word; combinational read of inst_addr_o.
- if_id_instr_o  out  32  registered instruction.
- if_id_pc4_o  out  32  registered PC+4 of that instruction.
- if_id_valid_o  out  1  IF/ID holds a real fetched instruction.
- op_o  out  6  if_id_instr_o[31:26]; feeds the control decoder opcode input.
- fetch_count_o  out  32  instructions accepted into IF/ID.
- stall_count_o  out  32  cycles in RUN with stall_i high.

## Operation
- FSM states:
  - IDLE: reset state. PC holds RESET_PC. IF/ID holds NOP_INSTR with valid 0.
  - IDLE -> RUN on the edge where start_i is 1; the first fetch happens in that same cycle's RUN successor.
  - RUN is left only by reset. start_i is ignored in RUN.
- Next-PC selection in RUN, in priority order:
  1. stall_i=1: PC, IF/ID and valid all hold. Redirects are ignored, because the ID instruction is re-evaluated next cycle.
  2. jump_i=1: PC <= {if_id_pc4_o[31:28], if_id_instr_o[25:0], 2'b00}. IF/ID <= NOP_INSTR, valid 0.
  3. branch_taken_i=1: PC <= branch_target_i. IF/ID <= NOP_INSTR, valid 0.
  4. Otherwise: PC <= PC+4. IF/ID <= {inst_data_i, PC+4}, valid 1.
- jump_i and branch_taken_i both high: jump wins.
- Redirects are taken only if if_id_valid_o=1; with valid 0 they are ignored.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. PC[1:0] is always 0; branch_target_i[1:0] is forced to 0.
- Counters are 32-bit and wrap at 2^32-1 -> 0.
  - fetch_count increments in case 4.
  - stall_count increments in RUN when stall_i=1.

## Timing
- Reset values: inst_addr_o=RESET_PC, if_id_instr_o=NOP_INSTR, if_id_pc4_o=0, if_id_valid_o=0, op_o=0, both counters 0, state IDLE.
- Reset asserted mid-RUN returns all of the above immediately (asynchronously). A stall or redirect pending in that cycle is discarded.
- Fetch latency is 1 cycle: the word at address A is on if_id_instr_o the cycle after inst_addr_o=A.
- Redirect penalty is 1 bubble: the target instruction appears on IF/ID 2 cycles after the redirect cycle.
- op_o is purely combinational from the register; the block has no combinational path from any input to op_o.
- inst_addr_o has no combinational input path; it is the PC register output.

## Structure
- Shared package cpu_pkg holds:
  - OP_J = 6'b000010, OP_BEQ = 6'b000100, OP_RTYPE = 6'b000000;
  - NOP_INSTR default;
  - fetch FSM state enum {FS_IDLE, FS_RUN}.
- One sub-module, pc_next_mux: combinational next-PC select and IF/ID next-value logic per the priority list above. The top level holds the FSM, PC, IF/ID registers and counters.

## Test plan
- Reset then start_i=1 for 1 cycle with memory[0..3]=add,lw,sw,beq: inst_addr_o steps 0,4,8,C. if_id_instr_o follows one cycle later. op_o shows 00,23,2B,04. fetch_count_o=4.
- stall_i=1 for 3 cycles while IF/ID holds lw at pc4=8: inst_addr_o stays 8, IF/ID is unchanged, stall_count_o=3. Fetch resumes at 8.
- branch_taken_i=1 with target 32'h40: next cycle inst_addr_o=0x40 and IF/ID valid=0 with NOP_INSTR. The word at 0x40 reaches IF/ID one cycle later.
- IF/ID holds j 0x0000100 with pc4 0x1000_0004, jump_i=1 and branch_taken_i=1 (target 0x80) together: PC becomes 0x1000_0400, not 0x80.
- stall_i=1 together with jump_i=1: PC is held and no flush occurs. After stall_i drops, the jump is taken.
- PC=0xFFFF_FFFC, no redirect: next PC is 0. Separately, assert rst_i mid-RUN between clock edges: outputs immediately show the reset values listed under Timing and the state is IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants, fetch state type and jump helper
package cpu_pkg;

    localparam logic [5:0]  OP_RTYPE          = 6'b000000;
    localparam logic [5:0]  OP_J              = 6'b000010;
    localparam logic [5:0]  OP_BEQ            = 6'b000100;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_RUN  = 1'b1
    } fetch_state_t;

    // J-type target: upper nibble of PC+4 joined with the word-aligned 26-bit index
    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [31:0] instr);
        return (pc4 & 32'hF000_0000) | ((instr << 2) & 32'h0FFF_FFFC);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: ID redirects, imem port, IF/ID outputs
interface fetch_stage_if;

    logic        start_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_data_i;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;
    logic [5:0]  op_o;
    logic [31:0] fetch_count_o;
    logic [31:0] stall_count_o;

    // Fetch stage side
    modport slave (
        input  start_i, stall_i, branch_taken_i, branch_target_i, jump_i, inst_data_i,
        output inst_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, op_o,
        output fetch_count_o, stall_count_o
    );

    // Pipeline / memory side
    modport master (
        output start_i, stall_i, branch_taken_i, branch_target_i, jump_i, inst_data_i,
        input  inst_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, op_o,
        input  fetch_count_o, stall_count_o
    );

endinterface

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - next-PC and IF/ID next-value select with stall/jump/branch priority
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        i_run,
    input  logic        i_stall,
    input  logic        i_jump,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_if_id_instr,
    input  logic [31:0] i_if_id_pc4,
    input  logic        i_if_id_valid,
    input  logic [31:0] i_inst_data,
    output logic [31:0] o_pc_next,
    output logic [31:0] o_instr_next,
    output logic [31:0] o_pc4_next,
    output logic        o_valid_next,
    output logic        o_fetch,
    output logic        o_stall
);

    logic [31:0] w_pc4;

    assign w_pc4 = i_pc + 32'd4;

    // Priority select; redirects only count when ID holds a real instruction
    always_comb begin
        o_pc_next    = i_pc;
        o_instr_next = i_if_id_instr;
        o_pc4_next   = i_if_id_pc4;
        o_valid_next = i_if_id_valid;
        o_fetch      = 1'b0;
        o_stall      = 1'b0;
        if (i_run) begin
            if (i_stall) begin
                o_stall = 1'b1;
            end else if (i_if_id_valid && i_jump) begin
                o_pc_next    = jump_target(i_if_id_pc4, i_if_id_instr);
                o_instr_next = NOP_INSTR;
                o_pc4_next   = 32'd0;
                o_valid_next = 1'b0;
            end else if (i_if_id_valid && i_branch_taken) begin
                o_pc_next    = i_branch_target & ~32'd3;
                o_instr_next = NOP_INSTR;
                o_pc4_next   = 32'd0;
                o_valid_next = 1'b0;
            end else begin
                o_pc_next    = w_pc4;
                o_instr_next = i_inst_data;
                o_pc4_next   = w_pc4;
                o_valid_next = 1'b1;
                o_fetch      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, IF/ID pipeline register, start FSM and counters
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_stage_if.slave  bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc4;
    logic        r_if_id_valid;
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    logic        w_run;
    logic [31:0] w_pc_next;
    logic [31:0] w_instr_next;
    logic [31:0] w_pc4_next;
    logic        w_valid_next;
    logic        w_fetch;
    logic        w_stall;

    assign w_run = (r_state == FS_RUN);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= FS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: IDLE waits for start, RUN is only left through reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FS_IDLE: if (bus.start_i) w_state_next = FS_RUN;
            FS_RUN:  w_state_next = FS_RUN;
            default: w_state_next = FS_IDLE;
        endcase
    end

    pc_next_mux #(
        .NOP_INSTR (NOP_INSTR)
    ) u_pc_next_mux (
        .i_run           (w_run),
        .i_stall         (bus.stall_i),
        .i_jump          (bus.jump_i),
        .i_branch_taken  (bus.branch_taken_i),
        .i_branch_target (bus.branch_target_i),
        .i_pc            (r_pc),
        .i_if_id_instr   (r_if_id_instr),
        .i_if_id_pc4     (r_if_id_pc4),
        .i_if_id_valid   (r_if_id_valid),
        .i_inst_data     (bus.inst_data_i),
        .o_pc_next       (w_pc_next),
        .o_instr_next    (w_instr_next),
        .o_pc4_next      (w_pc4_next),
        .o_valid_next    (w_valid_next),
        .o_fetch         (w_fetch),
        .o_stall         (w_stall)
    );

    // PC and IF/ID pipeline register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc          <= RESET_PC;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= 32'd0;
            r_if_id_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_if_id_instr <= w_instr_next;
            r_if_id_pc4   <= w_pc4_next;
            r_if_id_valid <= w_valid_next;
        end
    end

    // Fetch and stall counters, free-running with natural wrap
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_fetch) r_fetch_count <= r_fetch_count + 32'd1;
            if (w_stall) r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign bus.inst_addr_o   = r_pc;
    assign bus.if_id_instr_o = r_if_id_instr;
    assign bus.if_id_pc4_o   = r_if_id_pc4;
    assign bus.if_id_valid_o = r_if_id_valid;
    assign bus.op_o          = r_if_id_instr[31:26];
    assign bus.fetch_count_o = r_fetch_count;
    assign bus.stall_count_o = r_stall_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] W0   = 32'h0022_1820;  // add $3,$1,$2
    localparam logic [31:0] W4   = 32'h8C43_0000;  // lw
    localparam logic [31:0] W8   = 32'hAC43_0004;  // sw
    localparam logic [31:0] WC   = 32'h1022_0004;  // beq
    localparam logic [31:0] WJ   = 32'h0800_0100;  // j 0x0000100
    localparam logic [31:0] W40  = 32'h2000_0010;  // filler at 0x40
    localparam logic [31:0] WJT  = 32'h2000_0100;  // filler at 0x1000_0400
    localparam logic [31:0] WTOP = 32'h23FF_FFFF;  // filler at 0xFFFF_FFFC

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        chk_pc4;
    } exp_t;

    logic   clk;
    logic   rst;
    exp_t   sb[$];
    int     n_vec;
    int     n_err;

    fetch_stage_if u_if ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if.slave)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return W0;
            32'h0000_0004: return W4;
            32'h0000_0008: return W8;
            32'h0000_000C: return WC;
            32'h1000_0000: return WJ;
            default:       return {6'b001000, a[27:2]};
        endcase
    endfunction

    assign u_if.inst_data_i = mem_word(u_if.inst_addr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic st, input logic sl, input logic jp,
                        input logic bt, input logic [31:0] tgt,
                        input logic [31:0] e_addr, input logic [31:0] e_instr,
                        input logic [31:0] e_pc4, input logic e_valid, input logic chk_pc4);
        exp_t e;
        exp_t got;
        u_if.start_i         = st;
        u_if.stall_i         = sl;
        u_if.jump_i          = jp;
        u_if.branch_taken_i  = bt;
        u_if.branch_target_i = tgt;
        e.tag = tag; e.addr = e_addr; e.instr = e_instr; e.pc4 = e_pc4;
        e.valid = e_valid; e.chk_pc4 = chk_pc4;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_vec++;
        assert (sb.size() == 1) else begin
            n_err++;
            $error("FAIL %s_sb observed=%0d expected=1", tag, sb.size());
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk32({got.tag, "_addr"},  u_if.inst_addr_o,            got.addr);
            chk32({got.tag, "_instr"}, u_if.if_id_instr_o,          got.instr);
            chk32({got.tag, "_valid"}, {31'd0, u_if.if_id_valid_o}, {31'd0, got.valid});
            chk32({got.tag, "_op"},    {26'd0, u_if.op_o},          {26'd0, got.instr[31:26]});
            if (got.chk_pc4)
                chk32({got.tag, "_pc4"}, u_if.if_id_pc4_o, got.pc4);
        end
        @(negedge clk);
    endtask

    task automatic chk_counts(input string tag, input logic [31:0] fc, input logic [31:0] sc);
        chk32({tag, "_fetch_count"}, u_if.fetch_count_o, fc);
        chk32({tag, "_stall_count"}, u_if.stall_count_o, sc);
    endtask

    task automatic chk_reset(input string tag);
        chk32({tag, "_addr"},  u_if.inst_addr_o,            32'h0);
        chk32({tag, "_instr"}, u_if.if_id_instr_o,          NOP);
        chk32({tag, "_pc4"},   u_if.if_id_pc4_o,            32'h0);
        chk32({tag, "_valid"}, {31'd0, u_if.if_id_valid_o}, 32'h0);
        chk32({tag, "_op"},    {26'd0, u_if.op_o},          32'h0);
        chk_counts(tag, 32'd0, 32'd0);
        chk32({tag, "_state"}, {31'd0, dut.r_state},        {31'd0, FS_IDLE});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        u_if.start_i         = 1'b0;
        u_if.stall_i         = 1'b0;
        u_if.jump_i          = 1'b0;
        u_if.branch_taken_i  = 1'b0;
        u_if.branch_target_i = 32'h0;

        @(negedge clk);
        chk_reset("rst0");
        rst = 1'b0;

        // start, then straight-line fetch of add, lw
        step("start",  1, 0, 0, 0, 32'h0, 32'h0, NOP, 32'h0, 0, 1);
        step("f_add",  0, 0, 0, 0, 32'h0, 32'h4, W0,  32'h4, 1, 1);
        step("f_lw",   0, 0, 0, 0, 32'h0, 32'h8, W4,  32'h8, 1, 1);

        // three stall cycles holding lw; a branch during a stall is ignored
        step("stall1", 0, 1, 0, 0, 32'h0,   32'h8, W4, 32'h8, 1, 1);
        step("stall2", 0, 1, 0, 1, 32'h200, 32'h8, W4, 32'h8, 1, 1);
        step("stall3", 0, 1, 0, 0, 32'h0,   32'h8, W4, 32'h8, 1, 1);
        chk_counts("after_stall", 32'd2, 32'd3);

        step("f_sw",   0, 0, 0, 0, 32'h0, 32'hC,  W8, 32'hC,  1, 1);
        step("f_beq",  0, 0, 0, 0, 32'h0, 32'h10, WC, 32'h10, 1, 1);
        chk_counts("after_beq", 32'd4, 32'd3);

        // taken branch with misaligned target bits, then a branch while valid=0
        step("br_taken",   0, 0, 0, 1, 32'h43, 32'h40, NOP, 32'h0,  0, 0);
        step("br_novalid", 0, 0, 0, 1, 32'h80, 32'h44, W40, 32'h44, 1, 1);
        chk_counts("after_br", 32'd5, 32'd3);

        // reach the j instruction at 0x1000_0000
        step("br_far", 0, 0, 0, 1, 32'h1000_0000, 32'h1000_0000, NOP, 32'h0,         0, 0);
        step("f_j",    0, 0, 0, 0, 32'h0,         32'h1000_0004, WJ,  32'h1000_0004, 1, 1);

        // stall blocks the jump; once released, jump beats a simultaneous branch
        step("stall_jump",    0, 1, 1, 0, 32'h0,  32'h1000_0004, WJ,  32'h1000_0004, 1, 1);
        chk_counts("after_stall_jump", 32'd6, 32'd4);
        step("jump_beats_br", 0, 0, 1, 1, 32'h80, 32'h1000_0400, NOP, 32'h0,         0, 0);
        step("f_jtgt",        0, 0, 0, 0, 32'h0,  32'h1000_0404, WJT, 32'h1000_0404, 1, 1);

        // PC wrap from the top of the address space
        step("br_top",     0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,  32'h0, 0, 0);
        step("wrap",       0, 0, 0, 0, 32'h0,         32'h0,         WTOP, 32'h0, 1, 1);
        step("after_wrap", 0, 0, 0, 0, 32'h0,         32'h4,         W0,   32'h4, 1, 1);
        chk_counts("after_wrap", 32'd9, 32'd4);

        // asynchronous reset between edges with a stall and jump pending
        u_if.stall_i = 1'b1;
        u_if.jump_i  = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        @(negedge clk);
        rst = 1'b0;

        // back in IDLE: nothing fetches until start
        step("idle_hold",  0, 0, 0, 0, 32'h0, 32'h0, NOP, 32'h0, 0, 1);
        step("restart",    1, 0, 0, 0, 32'h0, 32'h0, NOP, 32'h0, 0, 1);
        step("refetch",    0, 0, 0, 0, 32'h0, 32'h4, W0,  32'h4, 1, 1);
        chk_counts("refetch", 32'd1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
